// File: rtl/ack_generator_pkg.sv
// ack_generator_pkg
//   Shared types and bus-level constants for the receiver ACK slot driver.
//   ack_state_t : FSM state encoding (IDLE, ARMED, DRIVE, DELIM)
//   DOMINANT    : bus level 0 (an ACK)
//   RECESSIVE   : bus level 1 (idle / not driving)
package ack_generator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      DRIVE = 2'd2,
      DELIM = 2'd3
   } ack_state_t;

   localparam logic DOMINANT  = 1'b0;
   localparam logic RECESSIVE = 1'b1;

endpackage

// File: rtl/ack_generator.sv
// ack_generator
//   Receiver-side ACK slot driver. After a frame is received with a good CRC,
//   it drives one dominant bit in the ACK slot and then checks the ACK
//   delimiter for a form error. ack_tx_bit is ANDed with the TX bitstream.
//
//   state | meaning
//   IDLE  | nothing pending, bus released
//   ARMED | good CRC seen, waiting for the ACK slot bit start
//   DRIVE | driving dominant for the single ACK slot bit
//   DELIM | released, waiting to sample the ACK delimiter
//
// Ports
//   clk          : controller clock
//   g_rst        : asynchronous active-high reset
//   tx_pt        : one-clk pulse at the bit-start point
//   smpl_pt      : one-clk pulse at the sample point
//   sampled_bit  : bus value at smpl_pt (0 = dominant)
//   ack_slt      : high during the ACK slot bit
//   ack_dlm      : high during the ACK delimiter bit
//   crc_chk_done : one-clk pulse when the CRC compare completes
//   crc_ok       : CRC matched, qualified by crc_chk_done
//   rx_role      : node is a receiver of the current frame
//   err_frm_tx   : error frame in progress (abort)
//   bus_off      : node is bus-off (abort)
//   ack_tx_bit   : registered bus drive value (0 = dominant ACK)
//   ack_bit_err  : pulse, bus recessive while driving the ACK
//   ack_dlm_err  : pulse, dominant sampled in the ACK delimiter
//   ack_sent     : pulse, ACK slot and delimiter completed cleanly
module ack_generator
   import ack_generator_pkg::*;
#(
   parameter int MAX_WAIT_BITS = 4,
   parameter int CNT_W         = 3
) (
   input  logic clk,
   input  logic g_rst,
   input  logic tx_pt,
   input  logic smpl_pt,
   input  logic sampled_bit,
   input  logic ack_slt,
   input  logic ack_dlm,
   input  logic crc_chk_done,
   input  logic crc_ok,
   input  logic rx_role,
   input  logic err_frm_tx,
   input  logic bus_off,
   output logic ack_tx_bit,
   output logic ack_bit_err,
   output logic ack_dlm_err,
   output logic ack_sent
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT_BITS);

   ack_state_t       state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next, cnt_sat;
   logic             bit_err_flag, bit_err_flag_next;
   logic             tx_bit_next;
   logic             bit_err_next, dlm_err_next, sent_next;
   logic             abort;

   assign abort   = err_frm_tx | bus_off;
   assign cnt_sat = (cnt >= MAX_CNT) ? MAX_CNT : cnt + CNT_W'(1);

   always_ff @(posedge clk or posedge g_rst) begin
      if (g_rst) begin
         state        <= IDLE;
         cnt          <= '0;
         bit_err_flag <= 1'b0;
         ack_tx_bit   <= RECESSIVE;
         ack_bit_err  <= 1'b0;
         ack_dlm_err  <= 1'b0;
         ack_sent     <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         bit_err_flag <= bit_err_flag_next;
         ack_tx_bit   <= tx_bit_next;
         ack_bit_err  <= bit_err_next;
         ack_dlm_err  <= dlm_err_next;
         ack_sent     <= sent_next;
      end
   end

   always_comb begin
      state_next        = state;
      cnt_next          = cnt;
      bit_err_flag_next = bit_err_flag;
      bit_err_next      = 1'b0;
      dlm_err_next      = 1'b0;
      sent_next         = 1'b0;

      if (abort) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt_next = '0;
               if (crc_chk_done && crc_ok && rx_role) begin
                  state_next = ARMED;
               end
            end
            ARMED: begin
               if (tx_pt) begin
                  if (ack_slt) begin
                     state_next = DRIVE;
                     cnt_next   = '0;
                  end else if (cnt_sat >= MAX_CNT) begin
                     state_next = IDLE;
                     cnt_next   = '0;
                  end else begin
                     cnt_next = cnt_sat;
                  end
               end
            end
            DRIVE: begin
               // Any bit start ends the drive: exactly one bit is ever driven.
               // A bit start that is not the delimiter means framing was lost.
               if (tx_pt) begin
                  state_next = ack_dlm ? DELIM : IDLE;
               end else if (smpl_pt && sampled_bit) begin
                  bit_err_next      = 1'b1;
                  bit_err_flag_next = 1'b1;
               end
            end
            DELIM: begin
               // A new bit start before the delimiter sample means the
               // delimiter was missed; give up without reporting anything.
               if (tx_pt) begin
                  state_next = IDLE;
               end else if (smpl_pt && ack_dlm) begin
                  state_next = IDLE;
                  if (sampled_bit == DOMINANT) begin
                     dlm_err_next = 1'b1;
                  end else if (!bit_err_flag) begin
                     sent_next = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end

      if (state_next == IDLE) begin
         bit_err_flag_next = 1'b0;
      end

      tx_bit_next = (state_next == DRIVE) ? DOMINANT : RECESSIVE;
   end

endmodule

// File: tb/tb_ack_generator.sv
// tb_ack_generator
//   Frame-level bench: each frame is described by a few parameters (CRC
//   result, role, wait bits before the ACK slot, bus levels in slot and
//   delimiter, optional abort cycle). The expected output waveform is
//   computed directly from those parameters and compared every cycle.
module tb_ack_generator;
   import ack_generator_pkg::*;

   localparam int B      = 8;   // clocks per bit
   localparam int SMPL   = 5;   // sample point offset within a bit
   localparam int CRC_C  = 2;   // cycle of crc_chk_done within a frame
   localparam int MAXW   = 4;
   localparam int MAXL   = 128;

   logic clk = 1'b0;
   logic g_rst;
   logic tx_pt, smpl_pt, sampled_bit, ack_slt, ack_dlm;
   logic crc_chk_done, crc_ok, rx_role, err_frm_tx, bus_off;
   logic ack_tx_bit, ack_bit_err, ack_dlm_err, ack_sent;

   int tests = 0;
   int fails = 0;

   logic exp_tx   [MAXL];
   logic exp_be   [MAXL];
   logic exp_de   [MAXL];
   logic exp_sent [MAXL];
   int   cmp_idx = 0;
   bit   cmp_on  = 1'b0;

   always #5 clk = ~clk;

   ack_generator #(.MAX_WAIT_BITS(MAXW), .CNT_W(3)) dut (
      .clk          (clk),
      .g_rst        (g_rst),
      .tx_pt        (tx_pt),
      .smpl_pt      (smpl_pt),
      .sampled_bit  (sampled_bit),
      .ack_slt      (ack_slt),
      .ack_dlm      (ack_dlm),
      .crc_chk_done (crc_chk_done),
      .crc_ok       (crc_ok),
      .rx_role      (rx_role),
      .err_frm_tx   (err_frm_tx),
      .bus_off      (bus_off),
      .ack_tx_bit   (ack_tx_bit),
      .ack_bit_err  (ack_bit_err),
      .ack_dlm_err  (ack_dlm_err),
      .ack_sent     (ack_sent)
   );

   task automatic check(input string name, input logic act, input logic expv, input int idx);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %b, expected %b", name, idx, act, expv);
      end
   endtask

   // Outputs for frame cycle c are visible just after the edge that
   // consumes the inputs of cycle c.
   always @(posedge clk) begin : compare
      int idx;
      bit on;
      idx = cmp_idx;
      on  = cmp_on;
      #2;
      if (on) begin
         check("ack_tx_bit",  ack_tx_bit,  exp_tx[idx],   idx);
         check("ack_bit_err", ack_bit_err, exp_be[idx],   idx);
         check("ack_dlm_err", ack_dlm_err, exp_de[idx],   idx);
         check("ack_sent",    ack_sent,    exp_sent[idx], idx);
      end
   end

   task automatic build_expect(input bit good, input int nwait, input logic slot_bus,
                               input logic dlm_bus, input int abort_at, input int len);
      int  s_c, d_c;
      bit  active;
      for (int c = 0; c < MAXL; c++) begin
         exp_tx[c] = 1'b1; exp_be[c] = 1'b0; exp_de[c] = 1'b0; exp_sent[c] = 1'b0;
      end
      active = good && (nwait < MAXW) && (abort_at != CRC_C);
      if (active) begin
         s_c = (nwait + 1) * B;
         d_c = s_c + B;
         for (int c = s_c; c < d_c; c++) exp_tx[c] = 1'b0;
         if (slot_bus) exp_be[s_c + SMPL] = 1'b1;
         if (!dlm_bus)      exp_de[d_c + SMPL]   = 1'b1;
         else if (!slot_bus) exp_sent[d_c + SMPL] = 1'b1;
      end
      if (abort_at > CRC_C) begin
         for (int c = abort_at; c < len; c++) begin
            exp_tx[c] = 1'b1; exp_be[c] = 1'b0; exp_de[c] = 1'b0; exp_sent[c] = 1'b0;
         end
      end
   endtask

   task automatic idle_inputs();
      tx_pt = 0; smpl_pt = 0; sampled_bit = 1; ack_slt = 0; ack_dlm = 0;
      crc_chk_done = 0; crc_ok = 0; rx_role = 0; err_frm_tx = 0; bus_off = 0;
   endtask

   // Frame: bit 0 carries crc_chk_done, nwait ordinary bits, ACK slot,
   // ACK delimiter, two trailing bits.
   task automatic run_frame(input logic ok, input logic rx, input int nwait,
                            input logic slot_bus, input logic dlm_bus,
                            input int abort_at, input bit use_bus_off);
      int len, bitn, off, s;
      len = (nwait + 5) * B;
      s   = nwait + 1;
      build_expect(ok && rx, nwait, slot_bus, dlm_bus, abort_at, len);
      for (int c = 0; c < len; c++) begin
         @(negedge clk);
         bitn = c / B;
         off  = c % B;
         tx_pt        = (off == 0);
         smpl_pt      = (off == SMPL);
         ack_slt      = (bitn == s);
         ack_dlm      = (bitn == s + 1);
         crc_chk_done = (c == CRC_C);
         crc_ok       = ok;
         rx_role      = rx;
         sampled_bit  = (bitn == s) ? slot_bus : (bitn == s + 1) ? dlm_bus : 1'($urandom);
         err_frm_tx   = (c == abort_at) && !use_bus_off;
         bus_off      = (c == abort_at) && use_bus_off;
         cmp_idx      = c;
         cmp_on       = 1'b1;
      end
      @(negedge clk);
      cmp_on = 1'b0;
      idle_inputs();
   endtask

   initial begin
      int nwait, len, ab;
      g_rst = 1'b1;
      idle_inputs();
      repeat (3) @(negedge clk);
      check("reset_ack_tx_bit",  ack_tx_bit,  1'b1, 0);
      check("reset_ack_bit_err", ack_bit_err, 1'b0, 0);
      check("reset_ack_dlm_err", ack_dlm_err, 1'b0, 0);
      check("reset_ack_sent",    ack_sent,    1'b0, 0);
      g_rst = 1'b0;
      repeat (2) @(negedge clk);

      // Good frame, ACK slot right after the CRC bit.
      run_frame(1, 1, 0, 0, 1, -1, 0);
      check("model_tx_before_slot", exp_tx[7],    1'b1, 7);
      check("model_tx_slot_first",  exp_tx[8],    1'b0, 8);
      check("model_tx_slot_last",   exp_tx[15],   1'b0, 15);
      check("model_tx_delim",       exp_tx[16],   1'b1, 16);
      check("model_sent",           exp_sent[21], 1'b1, 21);

      run_frame(0, 1, 1, 1, 1, -1, 0);        // bad CRC
      run_frame(1, 0, 1, 1, 1, -1, 0);        // transmitter role
      run_frame(1, 1, 2, 0, 0, -1, 0);        // dominant delimiter
      run_frame(1, 1, 1, 1, 1, -1, 0);        // slot overridden recessive
      run_frame(1, 1, 0, 0, 1, 10, 0);        // err_frm_tx mid-drive
      run_frame(1, 1, 0, 0, 1, 12, 1);        // bus_off mid-drive
      run_frame(1, 1, 1, 0, 1, CRC_C, 0);     // abort with crc_chk_done
      run_frame(1, 1, 3, 0, 1, -1, 0);        // last wait count that still drives
      run_frame(1, 1, 4, 0, 1, -1, 0);        // timeout
      run_frame(1, 1, 5, 0, 1, -1, 0);        // past timeout

      for (int i = 0; i < 120; i++) begin
         nwait = $urandom_range(0, 5);
         len   = (nwait + 5) * B;
         ab    = ($urandom % 4 == 0) ? int'($urandom_range(0, len - 1)) : -1;
         run_frame(1'($urandom % 4 != 0), 1'($urandom % 4 != 0), nwait,
                   1'($urandom % 5 == 0), 1'($urandom % 5 != 0), ab, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
